// File: rtl/fan_ctrl_multi.sv
// fan_ctrl_multi: NUM_CH PWM fan channels sharing one period counter.
// Each channel converts a signed demand to a target duty, kick-starts from
// OFF at full duty, slews toward the target, clamps to a minimum duty while
// running, and latches a sticky fault when the tach stops pulsing.
//
// Ports:
//   clk_i                 system clock
//   rst_i                 synchronous active-high reset
//   clk_en_PWM_i          PWM counter tick enable
//   periodCounterValue_i  PWM period in ticks (W+1 bits), 0 disables PWM
//   minCounterValue_i     minimum duty while running
//   slewStep_i            max duty change per period, 0 = unlimited
//   demand_valid_i        per-channel demand strobe
//   demand_i              signed demands, channel k at [k*(W+1) +: W+1]
//   tach_i                tach pulses, synchronous to clk_i
//   fault_clr_i           per-channel fault clear
//   PWM_pin_o             PWM outputs
//   duty_o                applied duty, channel k at [k*W +: W]
//   fault_o               sticky stall fault
//   periodStart_o         one-cycle pulse when cnt==0 first becomes visible
module fan_ctrl_multi #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned CNT_BITWIDTH  = 8,
  parameter int unsigned KICK_PERIODS  = 2,
  parameter int unsigned STALL_PERIODS = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clk_en_PWM_i,
  input  logic [CNT_BITWIDTH:0]            periodCounterValue_i,
  input  logic [CNT_BITWIDTH-1:0]          minCounterValue_i,
  input  logic [CNT_BITWIDTH-1:0]          slewStep_i,
  input  logic [NUM_CH-1:0]                demand_valid_i,
  input  logic [NUM_CH*(CNT_BITWIDTH+1)-1:0] demand_i,
  input  logic [NUM_CH-1:0]                tach_i,
  input  logic [NUM_CH-1:0]                fault_clr_i,
  output logic [NUM_CH-1:0]                PWM_pin_o,
  output logic [NUM_CH*CNT_BITWIDTH-1:0]   duty_o,
  output logic [NUM_CH-1:0]                fault_o,
  output logic                             periodStart_o
);

  localparam int unsigned W  = CNT_BITWIDTH;
  localparam int unsigned KW = (KICK_PERIODS > 0) ? $clog2(KICK_PERIODS + 1) : 1;
  localparam int unsigned SW = (STALL_PERIODS > 1) ? $clog2(STALL_PERIODS + 1) : 1;

  localparam logic [W:0]    CNT_ONE   = {{W{1'b0}}, 1'b1};
  localparam logic [KW-1:0] KICK_INIT = KW'(KICK_PERIODS);
  localparam logic [KW-1:0] KICK_ONE  = KW'(1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_PERIODS);
  localparam logic [SW-1:0] STALL_ONE = SW'(1);

  typedef enum logic [1:0] {ST_OFF, ST_KICK, ST_RUN, ST_FAULT} state_t;

  logic [W:0]    cnt;
  logic          boundary;
  state_t        state     [NUM_CH];
  logic [W-1:0]  target    [NUM_CH];
  logic [W-1:0]  duty      [NUM_CH];
  logic [KW-1:0] kick_cnt  [NUM_CH];
  logic [SW-1:0] stall_cnt [NUM_CH];
  logic [SW-1:0] stall_inc [NUM_CH];
  logic [NUM_CH-1:0] seen;
  logic [NUM_CH-1:0] seen_now;
  logic [NUM_CH-1:0] tach_q;

  // Negative demand is a speed request; magnitude saturates at full duty.
  function automatic logic [W-1:0] conv(input logic [W:0] d);
    logic [W:0] mag;
    mag = '0 - d;
    if (!d[W])      return '0;
    else if (mag[W]) return '1;
    else            return mag[W-1:0];
  endfunction

  function automatic logic [W-1:0] run_rule(input logic [W-1:0] cur,
                                            input logic [W-1:0] tgt,
                                            input logic [W-1:0] step,
                                            input logic [W-1:0] mn);
    logic [W-1:0] nxt;
    if (step == '0)
      nxt = tgt;
    else if (tgt > cur)
      nxt = ((tgt - cur) <= step) ? tgt : cur + step;
    else
      nxt = ((cur - tgt) <= step) ? tgt : cur - step;
    return (nxt < mn) ? mn : nxt;
  endfunction

  // Wrapping on >= also recovers if the period is shortened below cnt.
  always_comb begin
    boundary = clk_en_PWM_i && (periodCounterValue_i != '0) &&
               (cnt >= periodCounterValue_i - CNT_ONE);
  end

  // Boundary-cycle tach edges count toward the period that just ended.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      seen_now[k]  = seen[k] | (tach_i[k] & ~tach_q[k]);
      stall_inc[k] = stall_cnt[k] + STALL_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt           <= '0;
      periodStart_o <= 1'b0;
      PWM_pin_o     <= '0;
      seen          <= '0;
      tach_q        <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        state[k]     <= ST_OFF;
        target[k]    <= '0;
        duty[k]      <= '0;
        kick_cnt[k]  <= '0;
        stall_cnt[k] <= '0;
      end
    end else begin
      periodStart_o <= boundary;
      if (periodCounterValue_i == '0)
        cnt <= '0;
      else if (clk_en_PWM_i)
        cnt <= boundary ? '0 : cnt + CNT_ONE;

      for (int unsigned k = 0; k < NUM_CH; k++) begin
        tach_q[k]    <= tach_i[k];
        seen[k]      <= boundary ? 1'b0 : seen_now[k];
        PWM_pin_o[k] <= (periodCounterValue_i != '0) && (cnt < {1'b0, duty[k]});
        if (demand_valid_i[k])
          target[k] <= conv(demand_i[k*(W+1) +: W+1]);

        case (state[k])
          ST_OFF: begin
            duty[k] <= '0;
            if (boundary && target[k] != '0) begin
              if (KICK_PERIODS > 0) begin
                state[k]    <= ST_KICK;
                duty[k]     <= '1;
                kick_cnt[k] <= KICK_INIT;
              end else begin
                state[k]     <= ST_RUN;
                duty[k]      <= run_rule('0, target[k], slewStep_i, minCounterValue_i);
                stall_cnt[k] <= '0;
              end
            end
          end
          ST_KICK: begin
            if (boundary) begin
              if (target[k] == '0) begin
                state[k] <= ST_OFF;
                duty[k]  <= '0;
              end else if (kick_cnt[k] == KICK_ONE) begin
                state[k]     <= ST_RUN;
                kick_cnt[k]  <= '0;
                duty[k]      <= run_rule(duty[k], target[k], slewStep_i, minCounterValue_i);
                stall_cnt[k] <= '0;
              end else begin
                kick_cnt[k] <= kick_cnt[k] - KICK_ONE;
              end
            end
          end
          ST_RUN: begin
            if (boundary) begin
              // A stall takes priority over a stop request in the same period.
              if (!seen_now[k] && stall_inc[k] == STALL_LIM) begin
                state[k] <= ST_FAULT;
                duty[k]  <= '0;
              end else begin
                stall_cnt[k] <= seen_now[k] ? '0 : stall_inc[k];
                if (target[k] == '0) begin
                  state[k] <= ST_OFF;
                  duty[k]  <= '0;
                end else begin
                  duty[k] <= run_rule(duty[k], target[k], slewStep_i, minCounterValue_i);
                end
              end
            end
          end
          ST_FAULT: begin
            duty[k] <= '0;
            if (fault_clr_i[k])
              state[k] <= ST_OFF;
          end
          default: begin
            state[k] <= ST_OFF;
            duty[k]  <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    duty_o  = '0;
    fault_o = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      duty_o[k*W +: W] = duty[k];
      fault_o[k]       = (state[k] == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Bench for fan_ctrl_multi: stimulus pushes one expected record per period
// boundary; a monitor pops and compares at every periodStart_o pulse
// (duties, faults, and PWM high-time over the period that just ended).
module tb_fan_ctrl_multi;

  localparam int PER = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [8:0]  period;
  logic [7:0]  min_cnt;
  logic [7:0]  slew;
  logic [1:0]  dv;
  logic [17:0] demand;
  logic [1:0]  tach;
  logic [1:0]  fclr;
  logic [1:0]  pwm;
  logic [15:0] duty;
  logic [1:0]  fault;
  logic        pstart;

  logic [1:0]  tach_run;

  always #5 clk = ~clk;

  fan_ctrl_multi #(
    .NUM_CH(2),
    .CNT_BITWIDTH(8),
    .KICK_PERIODS(2),
    .STALL_PERIODS(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clk_en_PWM_i(clk_en),
    .periodCounterValue_i(period),
    .minCounterValue_i(min_cnt),
    .slewStep_i(slew),
    .demand_valid_i(dv),
    .demand_i(demand),
    .tach_i(tach),
    .fault_clr_i(fclr),
    .PWM_pin_o(pwm),
    .duty_o(duty),
    .fault_o(fault),
    .periodStart_o(pstart)
  );

  typedef struct {
    int d0;
    int d1;
    int f;
    int hi0;
    int hi1;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int prev0 = 0;
  int prev1 = 0;
  int acc0 = 0;
  int acc1 = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Expected high-time for the period that ends at this boundary follows
  // from the duty applied at the previous boundary.
  task automatic push(input int d0, input int d1, input int f);
    exp_t e;
    e.d0  = d0;
    e.d1  = d1;
    e.f   = f;
    e.hi0 = (prev0 > PER) ? PER : prev0;
    e.hi1 = (prev1 > PER) ? PER : prev1;
    prev0 = d0;
    prev1 = d1;
    sb.push_back(e);
  endtask

  task automatic wait_pulse();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pstart && n < 3 * PER);
    if (!pstart) begin
      checks++;
      failures++;
      $display("FAIL pulse_timeout actual=none required=periodStart_o within %0d cycles", 3 * PER);
    end
  endtask

  task automatic step(input int d0, input int d1, input int f);
    push(d0, d1, f);
    wait_pulse();
  endtask

  task automatic strobe(input int ch, input int val);
    logic [8:0] v;
    v = 9'(val);
    demand[ch*9 +: 9] = v;
    dv[ch] = 1'b1;
    @(negedge clk);
    dv = '0;
  endtask

  // Tach generator: toggles each enabled channel every 10 cycles.
  initial begin
    tach = '0;
    forever begin
      repeat (10) @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (tach_run[k]) tach[k] = ~tach[k];
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    int w0;
    int w1;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc0 = 0;
        acc1 = 0;
      end else if (pstart) begin
        w0 = acc0 + int'(pwm[0]);
        w1 = acc1 + int'(pwm[1]);
        acc0 = 0;
        acc1 = 0;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=pulse required=no pulse t=%0t", $time);
        end else begin
          e = sb.pop_front();
          check("duty0", int'(duty[7:0]), e.d0);
          check("duty1", int'(duty[15:8]), e.d1);
          check("fault", int'(fault), e.f);
          check("pwm_hi0", w0, e.hi0);
          check("pwm_hi1", w1, e.hi1);
        end
      end else begin
        acc0 += int'(pwm[0]);
        acc1 += int'(pwm[1]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int highs;
    rst      = 1'b1;
    clk_en   = 1'b1;
    period   = 9'(PER);
    min_cnt  = 8'd0;
    slew     = 8'd0;
    dv       = '0;
    demand   = '0;
    fclr     = '0;
    tach_run = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_duty", int'(duty), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_pwm", int'(pwm), 0);
    check("rst_pstart", int'(pstart), 0);

    // Kick then run at 60.
    rst = 1'b0;
    min_cnt = 8'd20;
    strobe(0, -60);
    step(255, 0, 0);
    step(255, 0, 0);
    step(60, 0, 0);

    // Slew-limited ramps, then clamp to minimum.
    slew = 8'd50;
    strobe(0, -200);
    step(110, 0, 0);
    step(160, 0, 0);
    step(200, 0, 0);
    step(200, 0, 0);
    strobe(0, -10);
    step(150, 0, 0);
    step(100, 0, 0);
    step(50, 0, 0);
    step(20, 0, 0);

    // Channel 1 with a dead tach: stall fault after 4 RUN boundaries.
    tach_run[1] = 1'b0;
    strobe(1, -100);
    step(20, 255, 0);
    step(20, 255, 0);
    step(20, 205, 0);
    step(20, 155, 0);
    step(20, 105, 0);
    step(20, 100, 0);
    step(20, 0, 2);
    step(20, 0, 2);
    fclr = 2'b11;
    @(negedge clk);
    fclr = '0;
    check("fault_clr", int'(fault), 0);
    tach_run[1] = 1'b1;
    step(20, 255, 0);
    step(20, 255, 0);
    step(20, 205, 0);
    step(20, 155, 0);

    // Saturating demand, positive demand stops, strobe on boundary cycle.
    slew = 8'd0;
    strobe(0, -256);
    step(255, 100, 0);
    step(255, 100, 0);
    strobe(0, 5);
    step(0, 100, 0);
    push(0, 100, 0);
    repeat (PER - 1) @(negedge clk);
    strobe(0, -50);
    check("boundary_strobe_pulse", int'(pstart), 1);
    step(255, 100, 0);
    step(255, 100, 0);
    step(50, 100, 0);

    // PWM disabled.
    period = '0;
    pulses = 0;
    highs  = 0;
    repeat (3 * PER) begin
      @(negedge clk);
      if (pstart) pulses++;
      if (pwm != '0) highs++;
    end
    check("p0_pulses", pulses, 0);
    check("p0_pwm_high_cycles", highs, 0);
    check("sb_drained", sb.size(), 0);

    // Reset in the middle of a kick.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    period = 9'(PER);
    rst = 1'b0;
    prev0 = 0;
    prev1 = 0;
    strobe(0, -30);
    step(255, 0, 0);
    repeat (30) @(negedge clk);
    check("kick_pwm", int'(pwm), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midkick_rst_duty", int'(duty), 0);
    check("midkick_rst_pwm", int'(pwm), 0);
    check("midkick_rst_fault", int'(fault), 0);
    check("midkick_rst_pstart", int'(pstart), 0);
    repeat (2) @(negedge clk);
    check("sb_final_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fan_ctrl_multi.md
# fan_ctrl_multi

Multi-channel successor to the single-fan controller. Drives `NUM_CH` PWM fan outputs from signed controller demands, one per channel. All channels share one period counter. Each channel adds a kick-start, a slew-rate limit, minimum-duty clamping and tachometer-based stall detection with a sticky fault. It sits between the per-channel PID cores (or a time-multiplexed PID) and the fan pins.

## Interface
Parameters:
- `NUM_CH`, 2, number of fan channels
- `CNT_BITWIDTH`, 8, duty/counter width W; demand width is W+1
- `KICK_PERIODS`, 2, full-duty periods applied on start from OFF (0 = no kick)
- `STALL_PERIODS`, 8, consecutive RUN periods without a tach edge that raise a fault (≥1)

Ports:
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset, synchronous, active-high
- `clk_en_PWM_i`  in  1  PWM counter tick enable
- `periodCounterValue_i`  in  W+1  PWM period in ticks; 0 = PWM disabled
- `minCounterValue_i`  in  W  minimum duty while running
- `slewStep_i`  in  W  maximum duty change per period; 0 = unlimited
- `demand_valid_i`  in  NUM_CH  per-channel demand strobe
- `demand_i`  in  NUM_CH*(W+1)  signed demands; channel k at `[k*(W+1) +: W+1]`
- `tach_i`  in  NUM_CH  tach pulses, already synchronised to `clk_i`
- `fault_clr_i`  in  NUM_CH  per-channel fault clear
- `PWM_pin_o`  out  NUM_CH  fan PWM outputs
- `duty_o`  out  NUM_CH*W  applied duty per channel
- `fault_o`  out  NUM_CH  sticky stall fault
- `periodStart_o`  out  1  one-cycle pulse at each period boundary

## Operation
- Period counter `cnt` (W+1 bits):
  - Advances only on cycles with `clk_en_PWM_i`=1.
  - On the tick where `cnt == periodCounterValue_i-1` it wraps to 0. That tick is the *boundary*.
  - If `periodCounterValue_i`=0: `cnt` is held at 0, no boundaries occur, all `PWM_pin_o`=0.
- Demand conversion, on `demand_valid_i[k]`: `target[k] = (d<0) ? min(-d, 2^W-1) : 0`.
  - −256 saturates to 255.
  - Values ≥0 mean off.
- Per-channel state machine. All transitions occur at a boundary, except the FAULT exit.
  - OFF: duty=0. At a boundary with target≠0:
    - if `KICK_PERIODS`>0 → KICK, duty=2^W−1, `kick_cnt`=`KICK_PERIODS`;
    - else → RUN and apply the RUN rule starting from duty 0.
  - KICK: at each boundary:
    - if target=0 → OFF, duty=0;
    - else decrement `kick_cnt`; on reaching 0 → RUN and apply the RUN rule from the current duty.
  - RUN: at each boundary:
    - if target=0 → OFF, duty=0 (no slew on stop);
    - else duty moves toward target by at most `slewStep_i` (exact target if `slewStep_i`=0 or distance ≤ step), then duty = max(duty, `minCounterValue_i`).
  - FAULT: duty=0. `fault_clr_i[k]`=1 on any cycle → OFF on the next cycle. `fault_clr_i` is ignored in other states.
- Stall detection, RUN only:
  - Tach rising edge = `tach_i & ~tach_q`.
  - A `seen` flag records any edge in the current period, including the boundary cycle itself.
  - At each boundary:
    - if `seen`=0, `stall_cnt`++;
    - else `stall_cnt`=0;
    - then `seen` is cleared.
  - When `stall_cnt` reaches `STALL_PERIODS` → FAULT, duty=0.
  - `stall_cnt` is cleared on entering RUN.
- `fault_o[k]` = (state==FAULT). `duty_o[k]` = duty register.
- PWM output: `PWM_pin_o[k]` is registered every clock as (`cnt < duty[k]`). Result: high for `duty` ticks per period, or constantly high if duty ≥ period.

## Timing
- Reset (synchronous, `rst_i`=1 at a clock edge) clears on that edge:
  - `cnt`, all `target`, `duty`, `kick_cnt`, `stall_cnt`, `seen`, `tach_q`;
  - states → OFF;
  - `PWM_pin_o`, `duty_o`, `fault_o`, `periodStart_o` → 0.
  - Reset mid-period or mid-kick aborts immediately.
- `periodStart_o` is registered and high for exactly the one cycle after the boundary edge, i.e. the cycle in which `cnt`=0 is first visible.
- `duty` updates on the boundary edge. `PWM_pin_o` reflects the new duty one clock later; duty never changes within a period (glitch-free).
- `demand_valid_i` updates `target` one cycle after the strobe.
  - A strobe coinciding with a boundary edge is not seen by that boundary's update; it takes effect at the next boundary.
- Stall detection and `fault_clr_i` on the same cycle: the fault is set and the clear is ignored.
- Channels are fully independent apart from the shared `cnt`.

## Test plan
(All scenarios use W=8, NUM_CH=2, KICK=2, STALL=4, period=100, `clk_en_PWM_i`=1.)
1. Reset, then demand −60 on ch0, min=20, slew=0, tach toggling → duty 255 for 2 periods, then 60; `PWM_pin_o[0]` high 60 of 100 cycles; ch1 stays 0.
2. RUN at 60, demand −200, slew=50 → duty 110, 160, 200 on successive boundaries; demand −10 → duty clamps to min 20.
3. RUN, `tach_i[1]` held constant → `fault_o[1]` rises at the 4th boundary, PWM low; `fault_clr_i[1]` pulse → OFF next cycle, restart with kick.
4. Demand −256 → target 255; demand +5 while RUN → OFF, duty 0 at the next boundary; a strobe on the boundary cycle is applied one period later.
5. `periodCounterValue_i`=0 → no `periodStart_o` pulses, outputs low; `rst_i` asserted mid-KICK → all outputs 0 on the next edge.
